// File: rtl/drink_code_lookup.sv
// Drink-code lookup: sequential scan of a rewritable code/stock table, one entry per cycle.
// Latency k+1 cycles for a hit at index k, DEPTH cycles for a miss; result held until resp_ready.
module drink_code_lookup #(
   parameter int CODE_W = 4,
   parameter int DEPTH  = 16,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CODE_W-1:0] req_code,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_found,
   output logic [IDX_W-1:0]  resp_idx,
   output logic              resp_avail,
   input  logic              tbl_we,
   input  logic [IDX_W-1:0]  tbl_addr,
   input  logic [CODE_W-1:0] tbl_code,
   input  logic              tbl_avail,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

   state_t              state_q;
   logic [CODE_W-1:0]   code_q [DEPTH];
   logic                avail_q [DEPTH];
   logic [CODE_W-1:0]   req_code_q;
   logic [IDX_W-1:0]    scan_q;
   logic                resp_valid_q;
   logic                resp_found_q;
   logic [IDX_W-1:0]    resp_idx_q;
   logic                resp_avail_q;
   logic                ready_q;
   logic                busy_q;

   logic                scan_hit;
   logic                scan_last;
   logic                wr_ok;

   // Compare reads the registered table, so a same-cycle write to entry scan_q is not seen.
   assign scan_hit  = (code_q[scan_q] == req_code_q);
   assign scan_last = (scan_q == IDX_W'(DEPTH - 1));
   assign wr_ok     = tbl_we && (32'(tbl_addr) < 32'(DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_code_q   <= '0;
         scan_q       <= '0;
         resp_valid_q <= 1'b0;
         resp_found_q <= 1'b0;
         resp_idx_q   <= '0;
         resp_avail_q <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            code_q[i]  <= CODE_W'(i);
            avail_q[i] <= 1'b1;
         end
      end else begin
         if (wr_ok) begin
            code_q[tbl_addr]  <= tbl_code;
            avail_q[tbl_addr] <= tbl_avail;
         end
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_code_q <= req_code;
                  scan_q     <= '0;
                  state_q    <= SCAN;
                  ready_q    <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            SCAN: begin
               if (scan_hit) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_found_q <= 1'b1;
                  resp_idx_q   <= scan_q;
                  resp_avail_q <= avail_q[scan_q];
               end else if (scan_last) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_found_q <= 1'b0;
                  resp_idx_q   <= '0;
                  resp_avail_q <= 1'b0;
               end else begin
                  scan_q <= scan_q + IDX_W'(1);
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  ready_q      <= 1'b1;
                  busy_q       <= 1'b0;
               end
            end
            default: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               ready_q      <= 1'b1;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_found = resp_found_q;
   assign resp_idx   = resp_idx_q;
   assign resp_avail = resp_avail_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_drink_code_lookup.sv
// Directed bench for drink_code_lookup: a 16-entry instance and a 12-entry instance.
module tb_drink_code_lookup;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0, resp_ready = 1'b0, tbl_we = 1'b0, tbl_avail = 1'b0;
   logic [3:0] req_code = '0, tbl_addr = '0, tbl_code = '0;
   logic       req_ready, resp_valid, resp_found, resp_avail, busy;
   logic [3:0] resp_idx;

   logic       b_req_valid = 1'b0, b_resp_ready = 1'b0, b_tbl_we = 1'b0, b_tbl_avail = 1'b0;
   logic [3:0] b_req_code = '0, b_tbl_addr = '0, b_tbl_code = '0;
   logic       b_req_ready, b_resp_valid, b_resp_found, b_resp_avail, b_busy;
   logic [3:0] b_resp_idx;

   int pass_cnt = 0;
   int total    = 0;

   always #5 clk = ~clk;

   drink_code_lookup #(.CODE_W(4), .DEPTH(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_code(req_code),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
      .resp_idx(resp_idx), .resp_avail(resp_avail),
      .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code), .tbl_avail(tbl_avail),
      .busy(busy)
   );

   drink_code_lookup #(.CODE_W(4), .DEPTH(12)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_code(b_req_code),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_found(b_resp_found),
      .resp_idx(b_resp_idx), .resp_avail(b_resp_avail),
      .tbl_we(b_tbl_we), .tbl_addr(b_tbl_addr), .tbl_code(b_tbl_code), .tbl_avail(b_tbl_avail),
      .busy(b_busy)
   );

   // All drive/sample activity happens 1ns after a rising edge.
   task automatic tbl_write(input logic [3:0] addr, input logic [3:0] code, input logic av);
      tbl_we = 1'b1; tbl_addr = addr; tbl_code = code; tbl_avail = av;
      @(posedge clk); #1;
      tbl_we = 1'b0;
   endtask

   task automatic respond();
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   // Returns cycles from accept edge to resp_valid; flags req_ready high or busy low while waiting.
   task automatic lookup(input logic [3:0] code, output int lat, output bit rdy_bad);
      req_code = code; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      rdy_bad = req_ready || !busy;
      while (!resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (req_ready || !busy) rdy_bad = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else pass_cnt++;
      total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); else pass_cnt++;
      total++; if ({resp_found, resp_idx, resp_avail} !== 6'd0)
         $display("FAIL reset_resp_fields got=%b/%0d/%b exp=0/0/0", resp_found, resp_idx, resp_avail); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
   endtask

   task automatic test_default_hit();
      int lat; bit rb;
      lookup(4'd5, lat, rb);
      total++; if (lat !== 6) $display("FAIL t1_latency got=%0d exp=6", lat); else pass_cnt++;
      total++; if ({resp_found, resp_idx, resp_avail} !== {1'b1, 4'd5, 1'b1})
         $display("FAIL t1_result got=%b/%0d/%b exp=1/5/1", resp_found, resp_idx, resp_avail); else pass_cnt++;
      total++; if (rb !== 1'b0) $display("FAIL t1_ready_low got=%b exp=0", rb); else pass_cnt++;
      respond();
      total++; if ({resp_valid, req_ready, busy} !== 3'b010)
         $display("FAIL t1_after_ack got=%b%b%b exp=010", resp_valid, req_ready, busy); else pass_cnt++;
   endtask

   task automatic test_write_stock();
      int lat; bit rb;
      tbl_write(4'd3, 4'd5, 1'b0);
      lookup(4'd5, lat, rb);
      total++; if (lat !== 4) $display("FAIL t2_latency got=%0d exp=4", lat); else pass_cnt++;
      total++; if ({resp_found, resp_idx, resp_avail} !== {1'b1, 4'd3, 1'b0})
         $display("FAIL t2_result got=%b/%0d/%b exp=1/3/0", resp_found, resp_idx, resp_avail); else pass_cnt++;
      respond();
   endtask

   task automatic test_duplicate();
      int lat; bit rb;
      tbl_write(4'd7, 4'd2, 1'b1);
      lookup(4'd2, lat, rb);
      total++; if (lat !== 3) $display("FAIL t3_latency got=%0d exp=3", lat); else pass_cnt++;
      total++; if ({resp_found, resp_idx, resp_avail} !== {1'b1, 4'd2, 1'b1})
         $display("FAIL t3_result got=%b/%0d/%b exp=1/2/1", resp_found, resp_idx, resp_avail); else pass_cnt++;
      respond();
   endtask

   task automatic test_miss_hold();
      int lat; bit rb;
      tbl_write(4'd9, 4'd0, 1'b1);
      lookup(4'd9, lat, rb);
      total++; if (lat !== 16) $display("FAIL t4_latency got=%0d exp=16", lat); else pass_cnt++;
      total++; if (rb !== 1'b0) $display("FAIL t4_ready_low got=%b exp=0", rb); else pass_cnt++;
      for (int c = 0; c < 5; c++) begin
         total++; if ({resp_valid, resp_found, resp_idx, resp_avail} !== 7'b1000000)
            $display("FAIL t4_hold cyc=%0d got=%b/%b/%0d/%b exp=1/0/0/0", c, resp_valid, resp_found, resp_idx, resp_avail);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      respond();
      total++; if (resp_valid !== 1'b0) $display("FAIL t4_after_ack got=%b exp=0", resp_valid); else pass_cnt++;
   endtask

   task automatic test_scan_write();
      int lat; bit rb;
      req_code = 4'd4; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      // Entry 4 is compared at the next edge; overwrite it on that same edge.
      tbl_we = 1'b1; tbl_addr = 4'd4; tbl_code = 4'd11; tbl_avail = 1'b0;
      @(posedge clk); #1;
      tbl_we = 1'b0;
      total++; if ({resp_valid, resp_found, resp_idx, resp_avail} !== {1'b1, 1'b1, 4'd4, 1'b1})
         $display("FAIL t5_old_value got=%b/%b/%0d/%b exp=1/1/4/1", resp_valid, resp_found, resp_idx, resp_avail);
      else pass_cnt++;
      respond();
      lookup(4'd4, lat, rb);
      total++; if ({lat[4:0], resp_found} !== {5'd16, 1'b0})
         $display("FAIL t5_old_gone lat=%0d found=%b exp=16/0", lat, resp_found); else pass_cnt++;
      respond();
      lookup(4'd11, lat, rb);
      total++; if ({lat[4:0], resp_found, resp_idx, resp_avail} !== {5'd5, 1'b1, 4'd4, 1'b0})
         $display("FAIL t5_new_value lat=%0d got=%b/%0d/%b exp=5 1/4/0", lat, resp_found, resp_idx, resp_avail);
      else pass_cnt++;
      respond();
   endtask

   task automatic test_reset_mid();
      int lat; bit rb;
      req_code = 4'd15; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++; if ({resp_valid, req_ready, busy} !== 3'b010)
         $display("FAIL t6_scan_reset got=%b%b%b exp=010", resp_valid, req_ready, busy); else pass_cnt++;
      lookup(4'd5, lat, rb);
      total++; if ({lat[4:0], resp_found, resp_idx, resp_avail} !== {5'd6, 1'b1, 4'd5, 1'b1})
         $display("FAIL t6_table_restored lat=%0d got=%b/%0d/%b exp=6 1/5/1", lat, resp_found, resp_idx, resp_avail);
      else pass_cnt++;
      respond();
      lookup(4'd0, lat, rb);
      total++; if ({resp_valid, resp_idx} !== {1'b1, 4'd0}) $display("FAIL t6_resp_reach got=%b/%0d exp=1/0", resp_valid, resp_idx); else pass_cnt++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      total++; if ({resp_valid, resp_found, req_ready, busy} !== 4'b0010)
         $display("FAIL t6_resp_reset got=%b%b%b%b exp=0010", resp_valid, resp_found, req_ready, busy); else pass_cnt++;
   endtask

   task automatic test_depth12();
      int lat;
      b_tbl_we = 1'b1; b_tbl_addr = 4'd13; b_tbl_code = 4'd13; b_tbl_avail = 1'b1;
      @(posedge clk); #1;
      b_tbl_we = 1'b0;
      b_req_code = 4'd13; b_req_valid = 1'b1;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      lat = 0;
      while (!b_resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++; if (lat !== 12) $display("FAIL t6_d12_latency got=%0d exp=12", lat); else pass_cnt++;
      total++; if ({b_resp_found, b_resp_idx, b_resp_avail} !== 6'd0)
         $display("FAIL t6_d12_write_ignored got=%b/%0d/%b exp=0/0/0", b_resp_found, b_resp_idx, b_resp_avail); else pass_cnt++;
      b_resp_ready = 1'b1;
      @(posedge clk); #1;
      b_resp_ready = 1'b0;
      b_req_code = 4'd11; b_req_valid = 1'b1;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      lat = 0;
      while (!b_resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      total++; if ({lat[4:0], b_resp_found, b_resp_idx} !== {5'd12, 1'b1, 4'd11})
         $display("FAIL t6_d12_last_hit lat=%0d got=%b/%0d exp=12 1/11", lat, b_resp_found, b_resp_idx); else pass_cnt++;
      b_resp_ready = 1'b1;
      @(posedge clk); #1;
      b_resp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_default_hit();
      test_write_stock();
      test_duplicate();
      test_miss_hold();
      test_scan_write();
      test_reset_mid();
      test_depth12();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
